act_sram_buf: RTL and testbench
===============================

# act_sram_buf

Parametrised activation SRAM buffer, the successor of the fixed 58101×1056b activation SRAM model. It generalises depth, channel count and activation width, and moves to rising-edge operation with a one-cycle registered read. New behaviour: a read-valid strobe, write-first bypass on same-address read/write, a hardware clear engine and out-of-range address detection. It sits between the conv/ResNet datapath and the activation storage; testbenches preload it through the retained `load_param` task.

## Interface
- CH_NUM, 24, channels per address
- ACT_PER_ADDR, 4, activations per channel per address
- BW_PER_ACT, 16, bits per activation
- DEPTH, 58101, number of words
- ADDR_W, 16, address width; must satisfy 2^ADDR_W ≥ DEPTH
- CLEAR_ON_RESET, 1, start clear engine on reset release
- Derived: NACT = CH_NUM*ACT_PER_ADDR; DW = NACT*BW_PER_ACT
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- clear_req  in  1  pulse; starts a full clear when idle
- busy  out  1  clear in progress; wr/rd ignored
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_mask  in  NACT  per-activation mask; 1 = keep old activation
- wr_data  in  DW  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data valid this cycle
- addr_err  out  1  one-cycle pulse: an accepted request had an address ≥ DEPTH

## Operation
- Mask expansion: activation i occupies bits [i*BW_PER_ACT +: BW_PER_ACT] and is controlled by wr_mask[i].
- Write: new = (wr_data & ~bitmask) | (mem[wr_addr] & bitmask), committed at the rising edge.
- Read: mem[rd_addr] is registered into rd_data at the rising edge, and rd_valid=1 in the same update.
- Same-cycle rd_en and wr_en to the same address: read returns the merged new word (write-first).
- Out of range (addr ≥ DEPTH): write is dropped; read returns all-zero with rd_valid=1; addr_err pulses. If both ports are out of range, addr_err still pulses once.
- FSM states:
  - IDLE → CLEAR on clear_req.
  - CLEAR: writes zero at clr_addr, clr_addr++ each cycle; → IDLE after addr DEPTH-1.
  - clear_req during CLEAR is ignored.
- While busy: wr_en/rd_en are ignored; rd_valid=0; addr_err=0.
- Reset: async; state = CLEAR if CLEAR_ON_RESET else IDLE; clr_addr=0. Memory array is not reset.
- Reset mid-clear restarts the clear from address 0.
- load_param(index, data): testbench task, direct zero-time array write.

## Timing
- Reset values: rd_data=0, rd_valid=0, addr_err=0, busy=CLEAR_ON_RESET.
- Read latency: request at edge N → rd_data/rd_valid visible after edge N (one cycle). rd_valid deasserts the cycle after rd_en=0; rd_data holds its last value.
- Write visible to a read issued on the following cycle.
- Clear duration: exactly DEPTH cycles after rst release or after the clear_req edge. busy deasserts after the edge that writes DEPTH-1. The first request is accepted on the next edge.
- addr_err aligned with rd_valid timing (one cycle after request).

## Structure
- Package act_sram_pkg: state enum {IDLE, CLEAR}, and functions for the NACT/DW width computation and DEPTH/ADDR_W legality check (elaboration-time $error).
- Sub-module act_mask_expand (NACT bits → DW bitmask, parametrised by BW_PER_ACT).
- Top holds the array, FSM, clear counter, bypass mux and output registers.

## Test plan
Bench config: DEPTH=16, CH_NUM=2, ACT_PER_ADDR=2, BW_PER_ACT=8 (DW=32) unless stated.
- Reset release with CLEAR_ON_RESET=1 → busy=1 for exactly 16 cycles; a read of addr 5 issued after busy falls returns 0x00000000 with rd_valid one cycle later.
- Write 0xAABBCCDD to addr 3 with mask 0000, then write 0x11223344 with mask 0101 → read of addr 3 returns 0x11BB33DD.
- Same-cycle write 0xDEADBEEF (mask 0) and read of addr 7 → rd_data=0xDEADBEEF one cycle later.
- Write to addr 16 → addr_err pulses one cycle; addr 0–15 unchanged. Read of addr 20 → rd_data=0, rd_valid=1, addr_err=1.
- load_param fills all addresses with 0xFFFFFFFF; clear_req pulse; assert rst at clear cycle 8; after release the clear runs a full 16 cycles and every address reads 0.
- rd_en/wr_en held during busy → no rd_valid, memory unchanged. Back-to-back reads of addrs 0,1,2 → three consecutive valid cycles, in order.

Source files
------------

// File: rtl/act_sram_buf_pkg.sv
// act_sram_pkg: shared types and elaboration-time helpers for act_sram_buf.
//   state_t    : controller state (IDLE / CLEAR)
//   calc_nact  : activations per word  = CH_NUM * ACT_PER_ADDR
//   calc_dw    : bits per word         = NACT * BW_PER_ACT
//   depth_ok   : 1 when DEPTH words are addressable with ADDR_W bits
package act_sram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int calc_nact(input int ch_num, input int act_per_addr);
    return ch_num * act_per_addr;
  endfunction

  function automatic int calc_dw(input int ch_num, input int act_per_addr,
                                 input int bw_per_act);
    return calc_nact(ch_num, act_per_addr) * bw_per_act;
  endfunction

  function automatic bit depth_ok(input int depth, input int addr_w);
    return (depth > 1) && (addr_w > 0) && (addr_w < 32) &&
           ((longint'(1) << addr_w) >= longint'(depth));
  endfunction

endpackage

// File: rtl/act_sram_buf_if.sv
// act_sram_buf_if: request/response bundle of the activation buffer.
//   master (datapath/bench): drives clear_req, wr_*, rd_*; receives busy,
//                            rd_data, rd_valid, addr_err
//   slave  (act_sram_buf)  : the reverse directions
interface act_sram_buf_if #(
  parameter int ADDR_W = 16,
  parameter int NACT   = 96,
  parameter int DW     = 1536
);
  logic              clear_req;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [NACT-1:0]   wr_mask;
  logic [DW-1:0]     wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              addr_err;

  modport master (
    output clear_req, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid, addr_err
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid, addr_err
  );
endinterface

// File: rtl/act_sram_buf_mask_expand.sv
// act_mask_expand: widens a per-activation keep mask to a per-bit mask.
//   mask    in  NACT                : 1 = keep the old activation
//   bitmask out NACT*BW_PER_ACT     : activation i -> bits [i*BW_PER_ACT +: BW_PER_ACT]
module act_mask_expand #(
  parameter int NACT       = 96,
  parameter int BW_PER_ACT = 16
) (
  input  logic [NACT-1:0]            mask,
  output logic [NACT*BW_PER_ACT-1:0] bitmask
);

  for (genvar g = 0; g < NACT; g++) begin : g_act
    assign bitmask[g*BW_PER_ACT +: BW_PER_ACT] = {BW_PER_ACT{mask[g]}};
  end

endmodule

// File: rtl/act_sram_buf.sv
// act_sram_buf: parametrised activation SRAM with registered read,
// write-first bypass, masked writes, a clear engine and address checking.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : act_sram_buf_if.slave (clear_req/busy, write port, read port,
//              rd_valid and addr_err strobes)
// load_param(index, data) is a zero-time preload hook for testbenches.
module act_sram_buf
  import act_sram_pkg::*;
#(
  parameter int CH_NUM         = 24,
  parameter int ACT_PER_ADDR   = 4,
  parameter int BW_PER_ACT     = 16,
  parameter int DEPTH          = 58101,
  parameter int ADDR_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst,
  act_sram_buf_if.slave bus
);

  localparam int NACT  = calc_nact(CH_NUM, ACT_PER_ADDR);
  localparam int DW    = calc_dw(CH_NUM, ACT_PER_ADDR, BW_PER_ACT);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  if (!depth_ok(DEPTH, ADDR_W)) begin : g_cfg_err
    $error("act_sram_buf: DEPTH=%0d is not addressable with ADDR_W=%0d", DEPTH, ADDR_W);
  end

  logic [DW-1:0]    mem [DEPTH];
  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_addr, clr_addr_nxt;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DW-1:0]    bitmask, wr_word;
  logic             wr_oob, rd_oob, wr_go, bypass;
  logic [DW-1:0]    rd_data_q;
  logic             rd_valid_q, addr_err_q;

  act_mask_expand #(
    .NACT       (NACT),
    .BW_PER_ACT (BW_PER_ACT)
  ) u_mask_expand (
    .mask    (bus.wr_mask),
    .bitmask (bitmask)
  );

  // Address range checks and masked merge; the merged word feeds both the
  // array write and the same-address read bypass.
  always_comb begin
    wr_idx  = bus.wr_addr[IDX_W-1:0];
    rd_idx  = bus.rd_addr[IDX_W-1:0];
    wr_oob  = bus.wr_addr > LAST_ADDR;
    rd_oob  = bus.rd_addr > LAST_ADDR;
    wr_go   = (state == IDLE) && bus.wr_en && !wr_oob;
    wr_word = (bus.wr_data & ~bitmask) | (mem[wr_idx] & bitmask);
    bypass  = wr_go && (bus.wr_addr == bus.rd_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_STATE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = '0;
    unique case (state)
      IDLE: begin
        if (bus.clear_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (clr_addr == LAST_IDX) state_nxt = IDLE;
        else                      clr_addr_nxt = clr_addr + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage has no reset; the clear engine owns the write port while busy.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_addr] <= '0;
    else if (wr_go)
      mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (state == CLEAR) begin
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      addr_err_q <= (bus.wr_en && wr_oob) || (bus.rd_en && rd_oob);
      if (bus.rd_en) begin
        if (rd_oob)      rd_data_q <= '0;
        else if (bypass) rd_data_q <= wr_word;
        else             rd_data_q <= mem[rd_idx];
      end
    end
  end

  assign bus.busy     = (state == CLEAR);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;

  task automatic load_param(input int unsigned index, input logic [DW-1:0] data);
    mem[IDX_W'(index)] <= data;
  endtask

endmodule

// File: tb/tb_act_sram_buf.sv
module tb_act_sram_buf;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;
  localparam int NACT   = 4;
  localparam int DW     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  act_sram_buf_if #(.ADDR_W(ADDR_W), .NACT(NACT), .DW(DW)) bus ();

  act_sram_buf #(
    .CH_NUM         (2),
    .ACT_PER_ADDR   (2),
    .BW_PER_ACT     (8),
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word array, remaining busy cycles, last read data.
  logic [31:0] m_mem [DEPTH];
  int          m_busy;
  logic [31:0] e_data;
  logic        e_valid, e_err, e_busy;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic        rd;
    logic [4:0]  ra;
    logic        x_valid;
    logic [31:0] x_data;
    logic        x_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] keep);
    logic [31:0] r;
    r = new_w;
    for (int i = 0; i < 4; i++)
      if (keep[i]) r[i*8 +: 8] = old_w[i*8 +: 8];
    return r;
  endfunction

  task automatic model_step(input logic clr, input logic wr, input logic [4:0] wa,
                            input logic [3:0] wm, input logic [31:0] wd,
                            input logic rd, input logic [4:0] ra);
    if (m_busy > 0) begin
      m_busy--;
      e_valid = 1'b0;
      e_err   = 1'b0;
    end else begin
      e_err = (wr && int'(wa) >= DEPTH) || (rd && int'(ra) >= DEPTH);
      if (wr && int'(wa) < DEPTH) m_mem[wa] = merge(m_mem[wa], wd, wm);
      e_valid = rd;
      if (rd) e_data = (int'(ra) >= DEPTH) ? 32'h0 : m_mem[ra];
      // A started clear leaves every word zero before any later access.
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_busy = DEPTH;
      end
    end
    e_busy = (m_busy > 0);
  endtask

  task automatic cycle(input logic clr, input logic wr, input logic [4:0] wa,
                       input logic [3:0] wm, input logic [31:0] wd,
                       input logic rd, input logic [4:0] ra);
    bus.clear_req = clr;
    bus.wr_en     = wr;
    bus.wr_addr   = wa;
    bus.wr_mask   = wm;
    bus.wr_data   = wd;
    bus.rd_en     = rd;
    bus.rd_addr   = ra;
    model_step(clr, wr, wa, wm, wd, rd, ra);
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(bus.rd_valid), 32'(e_valid));
    chk("addr_err", 32'(bus.addr_err), 32'(e_err));
    chk("busy",     32'(bus.busy),     32'(e_busy));
    chk("rd_data",  bus.rd_data,       e_data);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic read_cycle(input logic [4:0] ra);
    cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, ra);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_data",  bus.rd_data,        32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid),  32'h0);
    chk("rst_addr_err", 32'(bus.addr_err),  32'h0);
    chk("rst_busy",     32'(bus.busy),      32'h1);
  endtask

  initial begin
    bus.clear_req = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_mask   = '0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    e_data = 32'h0;

    tbl[0]  = '{1'b0, 5'd0,  4'b0000, 32'h0,        1'b1, 5'd5,  1'b1, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 5'd3,  4'b0000, 32'hAABBCCDD, 1'b0, 5'd0,  1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 5'd3,  4'b0101, 32'h11223344, 1'b0, 5'd0,  1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 5'd0,  4'b0000, 32'h0,        1'b1, 5'd3,  1'b1, 32'h11BB33DD, 1'b0};
    tbl[4]  = '{1'b1, 5'd7,  4'b0000, 32'hDEADBEEF, 1'b1, 5'd7,  1'b1, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{1'b1, 5'd16, 4'b0000, 32'h12345678, 1'b0, 5'd0,  1'b0, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 5'd0,  4'b0000, 32'h0,        1'b1, 5'd20, 1'b1, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b1, 5'd31, 4'b0000, 32'h5A5A5A5A, 1'b1, 5'd25, 1'b1, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 5'd0,  4'b0000, 32'h0,        1'b1, 5'd0,  1'b1, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b1, 5'd5,  4'b1111, 32'hFFFFFFFF, 1'b1, 5'd5,  1'b1, 32'h00000000, 1'b0};
    tbl[10] = '{1'b0, 5'd0,  4'b0000, 32'h0,        1'b1, 5'd3,  1'b1, 32'h11BB33DD, 1'b0};

    // Power-on reset, then the automatic clear.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    m_busy = DEPTH;
    e_data = 32'h0;
    repeat (DEPTH) idle_cycle();

    // Directed vectors.
    foreach (tbl[k]) begin
      cycle(1'b0, tbl[k].wr, tbl[k].wa, tbl[k].wm, tbl[k].wd, tbl[k].rd, tbl[k].ra);
      chk($sformatf("tbl%0d_valid", k), 32'(bus.rd_valid), 32'(tbl[k].x_valid));
      chk($sformatf("tbl%0d_err", k),   32'(bus.addr_err), 32'(tbl[k].x_err));
      if (tbl[k].x_valid) chk($sformatf("tbl%0d_data", k), bus.rd_data, tbl[k].x_data);
    end
    idle_cycle();

    // Back-to-back reads of distinct words.
    cycle(1'b0, 1'b1, 5'd0, 4'h0, 32'hA0A0A0A0, 1'b0, 5'd0);
    cycle(1'b0, 1'b1, 5'd1, 4'h0, 32'hB1B1B1B1, 1'b0, 5'd0);
    cycle(1'b0, 1'b1, 5'd2, 4'h0, 32'hC2C2C2C2, 1'b0, 5'd0);
    read_cycle(5'd0);
    chk("b2b_0", bus.rd_data, 32'hA0A0A0A0);
    read_cycle(5'd1);
    chk("b2b_1", bus.rd_data, 32'hB1B1B1B1);
    read_cycle(5'd2);
    chk("b2b_2", bus.rd_data, 32'hC2C2C2C2);
    idle_cycle();
    chk("b2b_valid_drop", 32'(bus.rd_valid), 32'h0);

    // Requests held through a clear are ignored.
    cycle(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b1, 1'b1, 5'(i % DEPTH), 4'h0, 32'hCAFE0000 | 32'(i), 1'b1, 5'(i % DEPTH));
    for (int i = 0; i < DEPTH; i++) read_cycle(5'(i));
    idle_cycle();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), 4'($urandom),
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)));
    end
    repeat (DEPTH + 1) idle_cycle();

    // Preload all ones, start a clear, reset it midway; the restart must
    // still zero every word and take the full clear length.
    for (int i = 0; i < DEPTH; i++) begin
      dut.load_param(i, 32'hFFFFFFFF);
      m_mem[i] = 32'hFFFFFFFF;
    end
    cycle(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd2);
    chk("preload_read", bus.rd_data, 32'hFFFFFFFF);
    repeat (8) idle_cycle();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_busy = DEPTH;
    e_data = 32'h0;
    repeat (DEPTH) idle_cycle();
    for (int i = 0; i < DEPTH; i++) read_cycle(5'(i));
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
